// File: rtl/min_max_finder_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : min_max_finder_param_if
//  Description : Bus bundle for min_max_finder_param: array write port,
//                scan start, scan results and state flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface min_max_finder_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    // Array write port and scan request
    logic             Wr_en;
    logic [AW-1:0]    Wr_addr;
    logic [WIDTH-1:0] Wr_data;
    logic             Start;

    // Scan results
    logic [WIDTH-1:0] Max;
    logic [WIDTH-1:0] Min;
    logic [AW-1:0]    Max_idx;
    logic [AW-1:0]    Min_idx;

    // Status and one-hot state flags
    logic             Done;
    logic             Busy;
    logic             Qi;
    logic             Ql;
    logic             Qc;
    logic             Qd;

    // Side that loads the array, starts scans and consumes results
    modport master (
        output Wr_en, Wr_addr, Wr_data, Start,
        input  Max, Min, Max_idx, Min_idx, Done, Busy, Qi, Ql, Qc, Qd
    );

    // Side that implements the finder
    modport slave (
        input  Wr_en, Wr_addr, Wr_data, Start,
        output Max, Min, Max_idx, Min_idx, Done, Busy, Qi, Ql, Qc, Qd
    );
endinterface
`default_nettype wire

// File: rtl/min_max_finder_param.sv
`default_nettype none
// ============================================================================
//  Module      : min_max_finder_param
//  Description : Parametrised min/max finder. Holds a DEPTH x WIDTH register
//                array loaded through a write port; on Start it scans the
//                array once (one element per clock, two comparators) and
//                reports maximum, minimum and the earliest index of each.
//                Comparison is unsigned or two's complement by parameter.
//  Revision    : 1.0 - initial release
// ============================================================================
module min_max_finder_param #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int SIGNED_MODE = 0
) (
    input  wire logic              Clk,
    input  wire logic              Reset_n,
    min_max_finder_param_if.slave  bus
);

    // Index width is derived from the array depth and never overridden.
    localparam int AW = $clog2(DEPTH);

    // Last index visited by the scan; the index counter stops here, so it
    // never wraps within a scan.
    localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH - 1);

    // One-hot state encoding. Bit positions double as the Q flag decode.
    localparam logic [3:0] c_ST_INI  = 4'b0001;
    localparam logic [3:0] c_ST_LOAD = 4'b0010;
    localparam logic [3:0] c_ST_CMP  = 4'b0100;
    localparam logic [3:0] c_ST_DONE = 4'b1000;

    localparam int c_BIT_INI  = 0;
    localparam int c_BIT_LOAD = 1;
    localparam int c_BIT_CMP  = 2;
    localparam int c_BIT_DONE = 3;

    logic [3:0]       r_state;
    logic [3:0]       w_state_nxt;

    // Element storage: deliberately without reset so it can map to plain
    // registers or a small RAM.
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [AW-1:0]    r_idx;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic [AW-1:0]    r_max_idx;
    logic [AW-1:0]    r_min_idx;

    logic [WIDTH-1:0] w_elem;
    logic             w_elem_gt;
    logic             w_elem_lt;
    logic             w_busy;
    logic             w_done;
    logic             w_last;

    // Element currently under comparison.
    assign w_elem = r_mem[r_idx];
    assign w_last = (r_idx == c_LAST_IDX);

    // Status flags come straight from the one-hot state bits.
    assign w_busy = r_state[c_BIT_LOAD] | r_state[c_BIT_CMP];
    assign w_done = r_state[c_BIT_DONE];

    // Both comparators look at the registered Max/Min, so the max and min
    // decisions for an element are independent of each other. Strict
    // comparisons keep ties from updating, which yields the earliest index.
    generate
        if (SIGNED_MODE != 0) begin : g_signed_cmp
            assign w_elem_gt = ($signed(w_elem) > $signed(r_max));
            assign w_elem_lt = ($signed(w_elem) < $signed(r_min));
        end else begin : g_unsigned_cmp
            assign w_elem_gt = (w_elem > r_max);
            assign w_elem_lt = (w_elem < r_min);
        end
    endgenerate

    // State register; reset parks the controller in INI at any time.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_ST_INI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection; any illegal encoding recovers to INI.
    always_comb begin
        w_state_nxt = c_ST_INI;
        case (r_state)
            c_ST_INI:  w_state_nxt = bus.Start ? c_ST_LOAD : c_ST_INI;
            c_ST_LOAD: w_state_nxt = c_ST_CMP;
            c_ST_CMP:  w_state_nxt = w_last ? c_ST_DONE : c_ST_CMP;
            c_ST_DONE: w_state_nxt = c_ST_INI;
            default:   w_state_nxt = c_ST_INI;
        endcase
    end

    // Array write port: writes only land while no scan is in progress so
    // the scanned data is stable; writes during LOAD/CMP are dropped.
    always_ff @(posedge Clk) begin
        if (bus.Wr_en && !w_busy) begin
            r_mem[bus.Wr_addr] <= bus.Wr_data;
        end
    end

    // Scan datapath: seed from element 0, then fold in one element per clock.
    // Results hold through DONE and INI until the next LOAD reseeds them.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_idx     <= '0;
            r_max     <= '0;
            r_min     <= '0;
            r_max_idx <= '0;
            r_min_idx <= '0;
        end else begin
            case (r_state)
                c_ST_INI: begin
                    r_idx <= '0;
                end
                c_ST_LOAD: begin
                    r_max     <= r_mem[0];
                    r_min     <= r_mem[0];
                    r_max_idx <= '0;
                    r_min_idx <= '0;
                    r_idx     <= AW'(1);
                end
                c_ST_CMP: begin
                    if (w_elem_gt) begin
                        r_max     <= w_elem;
                        r_max_idx <= r_idx;
                    end
                    if (w_elem_lt) begin
                        r_min     <= w_elem;
                        r_min_idx <= r_idx;
                    end
                    if (!w_last) begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    // Drive the result and status side of the bus.
    assign bus.Max     = r_max;
    assign bus.Min     = r_min;
    assign bus.Max_idx = r_max_idx;
    assign bus.Min_idx = r_min_idx;
    assign bus.Done    = w_done;
    assign bus.Busy    = w_busy;
    assign bus.Qi      = r_state[c_BIT_INI];
    assign bus.Ql      = r_state[c_BIT_LOAD];
    assign bus.Qc      = r_state[c_BIT_CMP];
    assign bus.Qd      = r_state[c_BIT_DONE];

endmodule
`default_nettype wire

// File: tb/tb_min_max_finder_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_min_max_finder_param
//  Description : Self-checking bench for min_max_finder_param. Three DUTs:
//                16x8 unsigned and 16x8 signed (sharing stimulus) plus a
//                4x12 unsigned instance. A behavioural model tracks array
//                contents and scan progress and predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_min_max_finder_param;

    localparam int DEPTH = 16;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b1;
    always #5 Clk = ~Clk;

    // Shared stimulus for the two 16x8 instances
    logic       wr_en   = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       start   = 1'b0;

    min_max_finder_param_if #(.WIDTH(8),  .DEPTH(16)) bus_u ();
    min_max_finder_param_if #(.WIDTH(8),  .DEPTH(16)) bus_s ();
    min_max_finder_param_if #(.WIDTH(12), .DEPTH(4))  bus_w ();

    assign bus_u.Wr_en   = wr_en;
    assign bus_u.Wr_addr = wr_addr;
    assign bus_u.Wr_data = wr_data;
    assign bus_u.Start   = start;
    assign bus_s.Wr_en   = wr_en;
    assign bus_s.Wr_addr = wr_addr;
    assign bus_s.Wr_data = wr_data;
    assign bus_s.Start   = start;

    min_max_finder_param #(.WIDTH(8), .DEPTH(16), .SIGNED_MODE(0)) u_dut_u (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus_u.slave));
    min_max_finder_param #(.WIDTH(8), .DEPTH(16), .SIGNED_MODE(1)) u_dut_s (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus_s.slave));
    min_max_finder_param #(.WIDTH(12), .DEPTH(4), .SIGNED_MODE(0)) u_dut_w (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus_w.slave));

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: array contents, cycles elapsed since a scan began,
    // and how many elements the visible results have absorbed so far.
    // ------------------------------------------------------------------
    logic [7:0] m_mem  [DEPTH];
    logic [7:0] m_snap [DEPTH];
    int         m_phase = 0;   // 0 idle, 1 seeding, 2..DEPTH comparing, DEPTH+1 done
    int         m_len   = 0;   // elements folded into results (0 = reset values)

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_phase <= 0;
            m_len   <= 0;
        end else begin
            if (wr_en && (m_phase == 0 || m_phase == DEPTH + 1))
                m_mem[wr_addr] <= wr_data;
            if (m_phase == 0) begin
                if (start) m_phase <= 1;
            end else if (m_phase == 1) begin
                m_snap  <= m_mem;
                m_len   <= 1;
                m_phase <= 2;
            end else if (m_phase <= DEPTH) begin
                m_len   <= m_len + 1;
                m_phase <= m_phase + 1;
            end else begin
                m_phase <= 0;
            end
        end
    end

    function automatic int sval(input logic [7:0] v, input bit sgn);
        return sgn ? int'($signed(v)) : int'(v);
    endfunction

    // Max/min with earliest index over the first m_len snapshot elements.
    task automatic expect_res(input bit sgn,
                              output logic [7:0] mx, output logic [3:0] mxi,
                              output logic [7:0] mn, output logic [3:0] mni);
        mx = '0; mn = '0; mxi = '0; mni = '0;
        if (m_len > 0) begin
            mx = m_snap[0];
            mn = m_snap[0];
            for (int k = 1; k < m_len; k++) begin
                if (sval(m_snap[k], sgn) > sval(mx, sgn)) begin mx = m_snap[k]; mxi = 4'(k); end
                if (sval(m_snap[k], sgn) < sval(mn, sgn)) begin mn = m_snap[k]; mni = 4'(k); end
            end
        end
    endtask

    task automatic cmp_bus(input string tag, input bit sgn,
                           input logic [7:0] amx, input logic [3:0] amxi,
                           input logic [7:0] amn, input logic [3:0] amni,
                           input logic abusy, input logic adone,
                           input logic aqi, input logic aql, input logic aqc, input logic aqd);
        logic [7:0] emx, emn;
        logic [3:0] emxi, emni;
        expect_res(sgn, emx, emxi, emn, emni);
        chk({tag, ".Max"},     32'(amx),  32'(emx));
        chk({tag, ".Max_idx"}, 32'(amxi), 32'(emxi));
        chk({tag, ".Min"},     32'(amn),  32'(emn));
        chk({tag, ".Min_idx"}, 32'(amni), 32'(emni));
        chk({tag, ".Busy"},    32'(abusy), 32'(m_phase >= 1 && m_phase <= DEPTH));
        chk({tag, ".Done"},    32'(adone), 32'(m_phase == DEPTH + 1));
        chk({tag, ".Qi"},      32'(aqi),   32'(m_phase == 0));
        chk({tag, ".Ql"},      32'(aql),   32'(m_phase == 1));
        chk({tag, ".Qc"},      32'(aqc),   32'(m_phase >= 2 && m_phase <= DEPTH));
        chk({tag, ".Qd"},      32'(aqd),   32'(m_phase == DEPTH + 1));
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge Clk) begin
        if (chk_en) begin
            cmp_bus("u", 1'b0, bus_u.Max, bus_u.Max_idx, bus_u.Min, bus_u.Min_idx,
                    bus_u.Busy, bus_u.Done, bus_u.Qi, bus_u.Ql, bus_u.Qc, bus_u.Qd);
            cmp_bus("s", 1'b1, bus_s.Max, bus_s.Max_idx, bus_s.Min, bus_s.Min_idx,
                    bus_s.Busy, bus_s.Done, bus_s.Qi, bus_s.Ql, bus_s.Qc, bus_s.Qd);
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    logic [7:0] pat [DEPTH];

    task automatic wr(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic fill_pat();
        for (int k = 0; k < DEPTH; k++) wr(k, pat[k]);
    endtask

    // Start a scan and wait for Done; optionally attempt a write mid-scan.
    task automatic run_scan(input string nm, input bit midwr);
        int cnt;
        if (bus_u.Done) step();
        start = 1'b1;
        step();
        start = 1'b0;
        cnt = 0;
        while (!bus_u.Done && cnt < 40) begin
            if (midwr && cnt == 3) begin
                wr_en = 1'b1; wr_addr = 4'd15; wr_data = 8'hFF;
            end else begin
                wr_en = 1'b0;
            end
            step();
            cnt++;
        end
        wr_en = 1'b0;
        chk({nm, ".latency"}, 32'(cnt), 32'd16);
    endtask

    task automatic res_u(input string nm, input logic [7:0] mx, input logic [3:0] mxi,
                         input logic [7:0] mn, input logic [3:0] mni);
        chk({nm, ".u.Max"}, 32'(bus_u.Max), 32'(mx));
        chk({nm, ".u.Max_idx"}, 32'(bus_u.Max_idx), 32'(mxi));
        chk({nm, ".u.Min"}, 32'(bus_u.Min), 32'(mn));
        chk({nm, ".u.Min_idx"}, 32'(bus_u.Min_idx), 32'(mni));
    endtask

    task automatic res_s(input string nm, input logic [7:0] mx, input logic [3:0] mxi,
                         input logic [7:0] mn, input logic [3:0] mni);
        chk({nm, ".s.Max"}, 32'(bus_s.Max), 32'(mx));
        chk({nm, ".s.Max_idx"}, 32'(bus_s.Max_idx), 32'(mxi));
        chk({nm, ".s.Min"}, 32'(bus_s.Min), 32'(mn));
        chk({nm, ".s.Min_idx"}, 32'(bus_s.Min_idx), 32'(mni));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [11:0] wv [4];
        int cnt;

        bus_w.Wr_en = 1'b0; bus_w.Wr_addr = '0; bus_w.Wr_data = '0; bus_w.Start = 1'b0;

        // Reset state
        Reset_n = 1'b0;
        repeat (3) step();
        chk_en = 1'b1;
        step();
        chk("reset.Max", 32'(bus_u.Max), 32'h0);
        chk("reset.Min", 32'(bus_u.Min), 32'h0);
        chk("reset.Busy", 32'(bus_u.Busy), 32'h0);
        chk("reset.Done", 32'(bus_u.Done), 32'h0);
        chk("reset.Qi", 32'(bus_u.Qi), 32'h1);
        Reset_n = 1'b1;
        step();

        // Unique max 0xF0 at 2, unique min 0x01 at 9
        for (int k = 0; k < DEPTH; k++) pat[k] = 8'(8'h30 + k);
        pat[0] = 8'h10; pat[1] = 8'h05; pat[2] = 8'hF0; pat[9] = 8'h01; pat[15] = 8'h33;
        fill_pat();
        run_scan("basic", 1'b0);
        res_u("basic", 8'hF0, 4'd2, 8'h01, 4'd9);
        res_s("basic", 8'h3E, 4'd14, 8'hF0, 4'd2);

        // Ties resolve to the earliest index
        for (int k = 0; k < DEPTH; k++) pat[k] = 8'h42;
        pat[5] = 8'h99; pat[12] = 8'h99; pat[3] = 8'h00; pat[14] = 8'h00;
        fill_pat();
        run_scan("ties", 1'b0);
        res_u("ties", 8'h99, 4'd5, 8'h00, 4'd3);

        // All equal
        for (int k = 0; k < DEPTH; k++) pat[k] = 8'h7F;
        fill_pat();
        run_scan("equal", 1'b0);
        res_u("equal", 8'h7F, 4'd0, 8'h7F, 4'd0);
        res_s("equal", 8'h7F, 4'd0, 8'h7F, 4'd0);

        // Signed vs unsigned ordering
        for (int k = 0; k < DEPTH; k++) pat[k] = 8'h01;
        pat[4] = 8'h80; pat[6] = 8'h7F; pat[8] = 8'hFF; pat[10] = 8'h00;
        fill_pat();
        run_scan("sgn", 1'b0);
        res_s("sgn", 8'h7F, 4'd6, 8'h80, 4'd4);
        res_u("sgn", 8'hFF, 4'd8, 8'h00, 4'd10);

        // Writes during a scan are dropped; a write in DONE is accepted
        for (int k = 0; k < DEPTH; k++) pat[k] = 8'(k);
        pat[7] = 8'h20;
        fill_pat();
        run_scan("wblk1", 1'b1);
        res_u("wblk1", 8'h20, 4'd7, 8'h00, 4'd0);
        run_scan("wblk2", 1'b0);
        res_u("wblk2", 8'h20, 4'd7, 8'h00, 4'd0);
        wr(15, 8'hFF);
        run_scan("wdone", 1'b0);
        res_u("wdone", 8'hFF, 4'd15, 8'h00, 4'd0);
        res_s("wdone", 8'h20, 4'd7, 8'hFF, 4'd15);

        // Reset in the 7th compare cycle aborts the scan immediately
        step();
        start = 1'b1; step(); start = 1'b0;
        repeat (7) step();
        Reset_n = 1'b0;
        #1;
        chk("midrst.Qi", 32'(bus_u.Qi), 32'h1);
        chk("midrst.Busy", 32'(bus_u.Busy), 32'h0);
        chk("midrst.Done", 32'(bus_u.Done), 32'h0);
        chk("midrst.Max", 32'(bus_u.Max), 32'h0);
        step();
        Reset_n = 1'b1;
        step();
        run_scan("rescan", 1'b0);
        res_u("rescan", 8'hFF, 4'd15, 8'h00, 4'd0);

        // 4 x 12-bit unsigned instance
        wv[0] = 12'h800; wv[1] = 12'h7FF; wv[2] = 12'h001; wv[3] = 12'hFFF;
        for (int k = 0; k < 4; k++) begin
            bus_w.Wr_en = 1'b1; bus_w.Wr_addr = 2'(k); bus_w.Wr_data = wv[k];
            step();
        end
        bus_w.Wr_en = 1'b0;
        bus_w.Start = 1'b1; step(); bus_w.Start = 1'b0;
        cnt = 0;
        while (!bus_w.Done && cnt < 20) begin step(); cnt++; end
        chk("w.latency", 32'(cnt), 32'd4);
        chk("w.Max", 32'(bus_w.Max), 32'hFFF);
        chk("w.Max_idx", 32'(bus_w.Max_idx), 32'd3);
        chk("w.Min", 32'(bus_w.Min), 32'h001);
        chk("w.Min_idx", 32'(bus_w.Min_idx), 32'd2);

        // Randomised traffic: writes at any time, frequent Start, rare resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                wr_en = 1'b0; start = 1'b0; Reset_n = 1'b0;
                step();
                Reset_n = 1'b1;
            end else begin
                wr_en   = ($urandom_range(0, 1) == 1);
                wr_addr = 4'($urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0:       wr_data = 8'h80;
                    1:       wr_data = 8'h7F;
                    default: wr_data = 8'($urandom);
                endcase
                if ($urandom_range(0, 5) == 0) wr_data = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
                start = ($urandom_range(0, 7) == 0);
                step();
            end
        end
        wr_en = 1'b0; start = 1'b0;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
